led_pattern_engine: RTL and testbench

Parametrised LED pattern generator for the board's LED bank, clocked from `clk_pll`. It is the next generation of the fixed 8-LED pattern block, with these additions:
- configurable LED count;
- a programmable step-rate prescaler;
- a bouncing pattern that reverses direction;
- PWM brightness control;
- an auto-cycle mode that steps through all patterns without host intervention.

It sits between the user-input register bank (pattern select, speed, brightness) and the LED output pins.

---
 rtl/led_pattern_engine.sv | 159 +++++++++++++++
 tb/tb_led_pattern_engine.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_engine.sv
`default_nettype none
// ============================================================================
//  Module   : led_pattern_engine
//  Purpose  : Parametrised LED pattern generator with step-rate prescaler,
//             bounce/LFSR/counter patterns, PWM dimming and auto-cycling.
//  Revision : 1.0 - initial release
// ============================================================================
module led_pattern_engine #(
  parameter int NUM_LEDS  = 8,
  parameter int DIV_WIDTH = 16,
  parameter int PWM_BITS  = 4
) (
  input  logic                 clk_pll,
  input  logic                 rstn,
  input  logic [2:0]           pattern_sel,
  input  logic                 auto_mode,
  input  logic [DIV_WIDTH-1:0] speed_div,
  input  logic [PWM_BITS-1:0]  brightness,
  output logic [NUM_LEDS-1:0]  led_out,
  output logic                 step_pulse,
  output logic [2:0]           active_pattern
);

  localparam int                c_IDX_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [c_IDX_W-1:0] c_POS_MAX = c_IDX_W'(NUM_LEDS - 1);
  localparam logic [NUM_LEDS-1:0] c_ONE    = NUM_LEDS'(1);
  localparam logic [15:0]       c_LFSR_SEED = 16'hACE1;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [2:0]           r_sel_q;
  logic                 r_auto_q;
  logic                 r_auto_prev;
  logic [2:0]           r_auto_idx;
  logic [DIV_WIDTH-1:0] r_tick_cnt;
  logic [15:0]          r_step;
  logic [15:0]          r_lfsr;
  logic [c_IDX_W-1:0]   r_pos;
  dir_t                 r_dir;
  logic [NUM_LEDS-1:0]  r_frame;
  logic [PWM_BITS-1:0]  r_pwm_cnt;

  logic                 w_tick;
  logic                 w_auto_first;
  logic                 w_auto_wrap;
  logic [2:0]           w_auto_idx_nxt;
  logic [2:0]           w_next_pat;
  logic                 w_restart;
  logic [15:0]          w_lfsr_upd;
  logic                 w_pwm_on;
  logic [c_IDX_W-1:0]   w_pos_tk;
  dir_t                 w_dir_tk;
  logic [2:0]           w_frame_pat;
  logic [15:0]          w_frame_step;
  logic [c_IDX_W-1:0]   w_frame_pos;
  logic [c_IDX_W-1:0]   w_run_idx;
  logic [NUM_LEDS-1:0]  w_alt;
  logic [NUM_LEDS-1:0]  w_frame_new;

  // Tick, pattern selection, restart detection, LFSR advance and PWM gate
  always_comb begin
    w_tick         = (r_tick_cnt >= speed_div);
    // auto index loads on the first cycle auto is seen, else steps on every 64-tick wrap
    w_auto_first   = r_auto_q & ~r_auto_prev;
    w_auto_wrap    = r_auto_q & w_tick & (r_step[5:0] == 6'd63);
    w_auto_idx_nxt = r_auto_idx;
    if (r_auto_q) begin
      if (w_auto_first)     w_auto_idx_nxt = r_sel_q;
      else if (w_auto_wrap) w_auto_idx_nxt = r_auto_idx + 3'd1;
    end
    w_next_pat = r_auto_q ? w_auto_idx_nxt : r_sel_q;
    w_restart  = (w_next_pat != active_pattern);
    w_lfsr_upd = w_tick ? {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]}
                        : r_lfsr;
    w_pwm_on   = (brightness == {PWM_BITS{1'b1}}) | (r_pwm_cnt < brightness);
  end

  // Bounce position for the next tick; direction flips on reaching either end
  always_comb begin
    w_pos_tk = r_pos;
    w_dir_tk = r_dir;
    if (r_dir == DIR_UP) begin
      w_pos_tk = r_pos + c_IDX_W'(1);
      w_dir_tk = (w_pos_tk == c_POS_MAX) ? DIR_DOWN : DIR_UP;
    end else begin
      w_pos_tk = r_pos - c_IDX_W'(1);
      w_dir_tk = (w_pos_tk == '0) ? DIR_UP : DIR_DOWN;
    end
  end

  // Frame value for the step about to be entered (step 0 of the new pattern on restart)
  always_comb begin
    w_frame_pat  = w_restart ? w_next_pat : active_pattern;
    w_frame_step = w_restart ? 16'd0 : (r_step + 16'd1);
    w_frame_pos  = w_restart ? '0 : w_pos_tk;
    w_run_idx    = c_IDX_W'(w_frame_step % 16'(NUM_LEDS));
    w_alt        = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      w_alt[i] = (((i % 2) == 1) == w_frame_step[0]);
    end
    case (w_frame_pat)
      3'd0:    w_frame_new = '0;
      3'd1:    w_frame_new = '1;
      3'd2:    w_frame_new = {NUM_LEDS{w_frame_step[0]}};
      3'd3:    w_frame_new = c_ONE << w_run_idx;
      3'd4:    w_frame_new = c_ONE << w_frame_pos;
      3'd5:    w_frame_new = w_alt;
      3'd6:    w_frame_new = w_lfsr_upd[NUM_LEDS-1:0];
      default: w_frame_new = w_frame_step[NUM_LEDS-1:0];
    endcase
  end

  // State registers; a restart takes priority over a tick on the same edge
  always_ff @(posedge clk_pll or negedge rstn) begin
    if (!rstn) begin
      r_sel_q        <= 3'd0;
      r_auto_q       <= 1'b0;
      r_auto_prev    <= 1'b0;
      r_auto_idx     <= 3'd0;
      r_tick_cnt     <= '0;
      r_step         <= 16'd0;
      r_lfsr         <= c_LFSR_SEED;
      r_pos          <= '0;
      r_dir          <= DIR_UP;
      r_frame        <= '0;
      r_pwm_cnt      <= '0;
      led_out        <= '0;
      step_pulse     <= 1'b0;
      active_pattern <= 3'd0;
    end else begin
      r_sel_q     <= pattern_sel;
      r_auto_q    <= auto_mode;
      r_auto_prev <= r_auto_q;
      r_auto_idx  <= w_auto_idx_nxt;
      r_lfsr      <= w_lfsr_upd;
      r_pwm_cnt   <= r_pwm_cnt + PWM_BITS'(1);
      led_out     <= r_frame & {NUM_LEDS{w_pwm_on}};
      step_pulse  <= w_tick & ~w_restart;
      if (w_restart) begin
        active_pattern <= w_next_pat;
        r_step         <= 16'd0;
        r_tick_cnt     <= '0;
        r_pos          <= '0;
        r_dir          <= DIR_UP;
        r_frame        <= w_frame_new;
      end else if (w_tick) begin
        r_step         <= r_step + 16'd1;
        r_tick_cnt     <= '0;
        r_pos          <= w_pos_tk;
        r_dir          <= w_dir_tk;
        r_frame        <= w_frame_new;
      end else begin
        r_tick_cnt     <= r_tick_cnt + DIV_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_pattern_engine
//  Purpose  : Randomised scoreboard bench for led_pattern_engine with a
//             behavioural frame model and a decoupled output monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_engine;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int PB = 4;

  logic          clk_pll = 1'b0;
  logic          rstn    = 1'b0;
  logic [2:0]    pattern_sel = 3'd0;
  logic          auto_mode   = 1'b0;
  logic [DW-1:0] speed_div   = '0;
  logic [PB-1:0] brightness  = '0;
  logic [N-1:0]  led_out;
  logic          step_pulse;
  logic [2:0]    active_pattern;

  led_pattern_engine #(.NUM_LEDS(N), .DIV_WIDTH(DW), .PWM_BITS(PB)) dut (
    .clk_pll        (clk_pll),
    .rstn           (rstn),
    .pattern_sel    (pattern_sel),
    .auto_mode      (auto_mode),
    .speed_div      (speed_div),
    .brightness     (brightness),
    .led_out        (led_out),
    .step_pulse     (step_pulse),
    .active_pattern (active_pattern)
  );

  always #5 clk_pll = ~clk_pll;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [N-1:0] led;
    logic         pulse;
    logic [2:0]   act;
  } exp_t;
  exp_t q[$];
  bit started = 0;
  bit done    = 0;

  // reference model state
  int           m_sel, m_auto_q, m_auto_prev, m_auto_idx, m_active;
  int           m_tick_cnt, m_step, m_k, m_pwm;
  logic [15:0]  m_lfsr;
  logic [N-1:0] m_frame, m_led;
  logic         m_pulse;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
    end
  endtask

  // LED picture for pattern pat at step s, k ticks after restart, LFSR value l
  function automatic logic [N-1:0] frame_of(int pat, int s, int k, logic [15:0] l);
    logic [N-1:0] f;
    int p;
    f = '0;
    case (pat)
      0: f = '0;
      1: f = '1;
      2: f = (s % 2 == 1) ? '1 : '0;
      3: f[s % N] = 1'b1;
      4: begin
        p = k % (2 * N - 2);
        if (p >= N) p = 2 * N - 2 - p;
        f[p] = 1'b1;
      end
      5: for (int i = 0; i < N; i++) f[i] = ((i % 2) == (s % 2));
      6: f = l[N-1:0];
      default: for (int i = 0; i < N; i++) f[i] = ((s >> i) & 1) == 1;
    endcase
    return f;
  endfunction

  // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
  function automatic logic [15:0] lfsr_adv(logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  task automatic model_reset();
    m_sel = 0; m_auto_q = 0; m_auto_prev = 0; m_auto_idx = 0; m_active = 0;
    m_tick_cnt = 0; m_step = 0; m_k = 0; m_pwm = 0;
    m_lfsr = 16'hACE1; m_frame = '0; m_led = '0; m_pulse = 1'b0;
  endtask

  task automatic model_clock();
    bit tick, first, wrap, restart, pon;
    int nxt_idx, nxt_pat;
    logic [15:0] ln;
    tick    = (m_tick_cnt >= int'(speed_div));
    first   = (m_auto_q == 1) && (m_auto_prev == 0);
    wrap    = (m_auto_q == 1) && tick && (m_step % 64 == 63);
    nxt_idx = m_auto_idx;
    if (m_auto_q == 1) begin
      if (first)     nxt_idx = m_sel;
      else if (wrap) nxt_idx = (m_auto_idx + 1) % 8;
    end
    nxt_pat = (m_auto_q == 1) ? nxt_idx : m_sel;
    restart = (nxt_pat != m_active);
    ln      = tick ? lfsr_adv(m_lfsr) : m_lfsr;
    pon     = (int'(brightness) == (1 << PB) - 1) || (m_pwm < int'(brightness));
    m_led   = pon ? m_frame : '0;
    m_pulse = tick && !restart;
    if (restart) begin
      m_active = nxt_pat; m_step = 0; m_k = 0; m_tick_cnt = 0;
      m_frame  = frame_of(nxt_pat, 0, 0, ln);
    end else if (tick) begin
      m_step = (m_step + 1) % 65536; m_k++; m_tick_cnt = 0;
      m_frame = frame_of(m_active, m_step, m_k, ln);
    end else begin
      m_tick_cnt++;
    end
    m_lfsr      = ln;
    m_auto_idx  = nxt_idx;
    m_auto_prev = m_auto_q;
    m_auto_q    = int'(auto_mode);
    m_sel       = int'(pattern_sel);
    m_pwm       = (m_pwm + 1) % (1 << PB);
  endtask

  // Called at a negedge with inputs settled: predict the next posedge, then advance
  task automatic apply(input int ncyc);
    exp_t e;
    repeat (ncyc) begin
      if (!rstn) model_reset();
      else       model_clock();
      e.led = m_led; e.pulse = m_pulse; e.act = 3'(m_active);
      q.push_back(e);
      started = 1;
      @(negedge clk_pll);
    end
  endtask

  // Monitor: pops one expectation per clock and compares all outputs
  initial begin
    exp_t e;
    wait (started);
    forever begin
      @(posedge clk_pll);
      #1;
      if (!done) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL scoreboard_empty at %0t: got no expectation expected one", $time);
        end else begin
          e = q.pop_front();
          check("led_out", int'(led_out), int'(e.led));
          check("step_pulse", int'(step_pulse), int'(e.pulse));
          check("active_pattern", int'(active_pattern), int'(e.act));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog at %0t: got timeout expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int act_hist[$];
    int n6, n7;
    model_reset();
    pattern_sel = 3'($urandom_range(0, 7));
    auto_mode   = 1'($urandom_range(0, 1));
    speed_div   = DW'($urandom_range(0, 5));
    brightness  = PB'($urandom_range(0, 15));
    @(negedge clk_pll);
    check("reset_led_out", int'(led_out), 0);
    check("reset_step_pulse", int'(step_pulse), 0);
    check("reset_active_pattern", int'(active_pattern), 0);
    apply(3);
    rstn = 1'b1;
    pattern_sel = 3'd0; auto_mode = 1'b0; speed_div = '0; brightness = 4'hF;
    apply(4);

    // running light, then bounce
    pattern_sel = 3'd3; apply(24);
    pattern_sel = 3'd4; apply(40);

    // prescaler, then a drop of speed_div below the running count
    pattern_sel = 3'd7; speed_div = 16'd3; apply(21);
    speed_div = 16'd0; apply(10);

    // PWM dimming of the all-on pattern
    pattern_sel = 3'd1; brightness = 4'd4; apply(6);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (led_out == 8'hFF) cnt++;
      apply(1);
    end
    check("pwm_on_count_b4", cnt, 4);
    brightness = 4'd0; apply(20);
    brightness = 4'hF; apply(20);

    // auto-cycle from pattern 6
    pattern_sel = 3'd6; auto_mode = 1'b1;
    for (int i = 0; i < 200; i++) begin
      act_hist.push_back(int'(active_pattern));
      apply(1);
    end
    n6 = 0; n7 = 0;
    foreach (act_hist[i]) begin
      if (act_hist[i] == 6) n6++;
      if (act_hist[i] == 7) n7++;
    end
    check("auto_cycles_on_6", n6, 64);
    check("auto_cycles_on_7", n7, 64);
    auto_mode = 1'b0; apply(12);

    // asynchronous reset in the middle of the running light
    pattern_sel = 3'd3; apply(11);
    rstn = 1'b0;
    #1;
    check("async_reset_led_out", int'(led_out), 0);
    check("async_reset_active", int'(active_pattern), 0);
    model_reset();
    apply(2);
    rstn = 1'b1; apply(20);

    // randomised traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0)  pattern_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 149) == 0) auto_mode   = ~auto_mode;
      if ($urandom_range(0, 29) == 0)  speed_div   = DW'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0)   brightness  = PB'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) rstn = 1'b0;
      else                             rstn = 1'b1;
      apply(1);
    end

    done = 1;
    @(posedge clk_pll);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
